// File: rtl/reg_bank_mp.sv
// ---------------------------------------------------------------------------
// reg_bank_mp -- decode-stage register file with pending-write scoreboard.
//
// Purpose:
//   NUM_REGS x DATA_WIDTH register bank (register 0 hardwired to zero) with
//   NUM_RD registered read ports, two prioritised write ports and a
//   per-register "pending" bit that tracks issued-but-unwritten results so
//   decode can stall on a RAW hazard. Reads see same-cycle writes through a
//   bypass.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   rd_en        per-port read request                  [NUM_RD]
//   rd_addr      packed read addresses                  [NUM_RD*ADDR_WIDTH]
//   rd_data      packed registered read data            [NUM_RD*DATA_WIDTH]
//   rd_valid     one cycle after an accepted read       [NUM_RD]
//   rd_pending   source register was awaiting a write   [NUM_RD]
//   wa_*         write port A (ALU writeback, high priority)
//   wb_*         write port B (load return, low priority)
//   issue_*      marks a destination register pending
//   any_pending  registered OR of all pending bits
// ---------------------------------------------------------------------------
module reg_bank_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic [NUM_RD-1:0]              rd_pending,
  input  logic                           wa_en,
  input  logic [ADDR_WIDTH-1:0]          wa_addr,
  input  logic [DATA_WIDTH-1:0]          wa_data,
  input  logic                           wb_en,
  input  logic [ADDR_WIDTH-1:0]          wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  output logic                           any_pending
);

  // Current register contents and pending bits, plus next-state pending
  // vector (used so any_pending reflects the vector after the edge).
  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q_vec;
  logic [NUM_REGS-1:0]   pend_d_vec;
  logic                  any_pending_q;

  // -------------------------------------------------------------------------
  // Storage and scoreboard, one slice per register
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Register 0 has no storage: always zero, never pending.
        assign reg_val[gi]    = '0;
        assign pend_q_vec[gi] = 1'b0;
        assign pend_d_vec[gi] = 1'b0;
      end else begin : g_live
        logic                  wa_hit;
        logic                  wb_hit;
        logic                  iss_hit;
        logic [DATA_WIDTH-1:0] data_q;
        logic [DATA_WIDTH-1:0] data_d;
        logic                  pend_q;
        logic                  pend_d;

        assign wa_hit  = wa_en    && (wa_addr    == ADDR_WIDTH'(gi));
        assign wb_hit  = wb_en    && (wb_addr    == ADDR_WIDTH'(gi));
        assign iss_hit = issue_en && (issue_addr == ADDR_WIDTH'(gi));

        // Port A wins a same-address collision; port B's write is dropped.
        always_comb begin
          data_d = data_q;
          if (wa_hit) begin
            data_d = wa_data;
          end else if (wb_hit) begin
            data_d = wb_data;
          end
        end

        // A committed write retires the pending result, but a same-cycle
        // issue to the same register starts a new one, so the set wins.
        always_comb begin
          pend_d = pend_q;
          if (wa_hit || wb_hit) begin
            pend_d = 1'b0;
          end
          if (iss_hit) begin
            pend_d = 1'b1;
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
          end else begin
            data_q <= data_d;
            pend_q <= pend_d;
          end
        end

        assign reg_val[gi]    = data_q;
        assign pend_q_vec[gi] = pend_q;
        assign pend_d_vec[gi] = pend_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_pending_q <= 1'b0;
    end else begin
      any_pending_q <= |pend_d_vec;
    end
  end

  assign any_pending = any_pending_q;

  // -------------------------------------------------------------------------
  // Read ports, fully independent of each other
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic                  wa_hit;
      logic                  wb_hit;
      logic [DATA_WIDTH-1:0] data_q;
      logic [DATA_WIDTH-1:0] data_d;
      logic                  valid_q;
      logic                  valid_d;
      logic                  pend_q;
      logic                  pend_d;

      assign addr   = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wa_hit = wa_en && (wa_addr == addr);
      assign wb_hit = wb_en && (wb_addr == addr);

      // Bypass priority mirrors write priority: A, then B, then storage.
      // Pending is cleared by a same-cycle write because the value being
      // returned is already the written result; a same-cycle issue is only
      // visible from the next cycle onward.
      always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        pend_d  = 1'b0;
        if (rd_en[gi]) begin
          valid_d = 1'b1;
          if (addr == '0) begin
            data_d = '0;
          end else if (wa_hit) begin
            data_d = wa_data;
          end else if (wb_hit) begin
            data_d = wb_data;
          end else begin
            data_d = reg_val[addr];
          end
          pend_d = pend_q_vec[addr] && !(wa_hit || wb_hit);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          pend_q  <= pend_d;
        end
      end

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign rd_valid[gi]                         = valid_q;
      assign rd_pending[gi]                       = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_reg_bank_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_mp -- self-checking bench for reg_bank_mp.
//
// Directed steps from the test plan followed by a randomized run, all checked
// against a behavioural model (plain arrays updated with the register-file
// rules) plus explicit constant expectations for the directed steps.
// ---------------------------------------------------------------------------
module tb_reg_bank_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_valid;
  logic [NRD-1:0]    rd_pending;
  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [DW-1:0]     wa_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              any_pending;

  int checks = 0;
  int errors = 0;

  reg_bank_mp #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_RD(NRD)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_pending(rd_pending),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .any_pending(any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  logic [DW-1:0] m_reg  [NR];
  bit            m_pend [NR];
  logic [DW-1:0] e_data [NRD];
  bit            e_valid[NRD];
  bit            e_pend [NRD];
  bit            e_any;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 1'b0;
    end
    for (int p = 0; p < NRD; p++) begin
      e_data[p]  = '0;
      e_valid[p] = 1'b0;
      e_pend[p]  = 1'b0;
    end
    e_any = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [AW-1:0] a;
    bit written;
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*AW +: AW];
        written = (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
        if (a == 0)                      e_data[p] = '0;
        else if (wa_en && wa_addr == a)  e_data[p] = wa_data;
        else if (wb_en && wb_addr == a)  e_data[p] = wb_data;
        else                             e_data[p] = m_reg[a];
        e_valid[p] = 1'b1;
        e_pend[p]  = m_pend[a] && !written;
      end else begin
        e_valid[p] = 1'b0;
        e_pend[p]  = 1'b0;
      end
    end
    // Low-priority write first so that port A overwrites on a collision.
    if (wb_en && wb_addr != 0) begin
      m_reg[wb_addr]  = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (wa_en && wa_addr != 0) begin
      m_reg[wa_addr]  = wa_data;
      m_pend[wa_addr] = 1'b0;
    end
    if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    e_any = 1'b0;
    for (int r = 0; r < NR; r++) e_any = e_any | m_pend[r];
  endtask

  task automatic check_model(input string tag);
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s_data%0d", tag, p), 64'(rd_data[p*DW +: DW]), 64'(e_data[p]));
      chk($sformatf("%s_valid%0d", tag, p), 64'(rd_valid[p]), 64'(e_valid[p]));
      chk($sformatf("%s_pend%0d", tag, p), 64'(rd_pending[p]), 64'(e_pend[p]));
    end
    chk($sformatf("%s_any", tag), 64'(any_pending), 64'(e_any));
  endtask

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s_data", tag), 64'(rd_data), 64'h0);
    chk($sformatf("%s_valid", tag), 64'(rd_valid), 64'h0);
    chk($sformatf("%s_pend", tag), 64'(rd_pending), 64'h0);
    chk($sformatf("%s_any", tag), 64'(any_pending), 64'h0);
  endtask

  // One transaction: model the edge, clock the DUT, compare 1 ns later.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
    $display("txn %-12s rd_en=%b addr=%h wa=%b/%0d wb=%b/%0d iss=%b/%0d -> data=%h val=%b pend=%b any=%b",
             tag, rd_en, rd_addr, wa_en, wa_addr, wb_en, wb_addr, issue_en, issue_addr,
             rd_data, rd_valid, rd_pending, any_pending);
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic randomize_inputs();
    rd_en      = NRD'($urandom);
    // Narrow address range makes bypass, collision and scoreboard hits common.
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
    wa_en      = 1'($urandom);
    wa_addr    = AW'($urandom_range(0, 7));
    wa_data    = $urandom;
    wb_en      = 1'($urandom);
    wb_addr    = AW'($urandom_range(0, 7));
    wb_data    = $urandom;
    issue_en   = 1'($urandom);
    issue_addr = AW'($urandom_range(0, 7));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();

    // Reset held with random inputs: everything stays zero.
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      @(posedge clk);
      #1;
      check_all_zero($sformatf("rst_hold%0d", k));
    end
    idle();
    rst = 1'b1;

    // Read register 5 after release.
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd5;
    cycle("rel_rd5");
    chk("rel_rd5_val", 64'(rd_valid[0]), 64'h1);
    chk("rel_rd5_data", 64'(rd_data[31:0]), 64'h0);

    // Write then read on both ports.
    idle(); wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF;
    cycle("wr3");
    idle(); rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    cycle("rd3");
    chk("rd3_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("rd3_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    chk("rd3_pend", 64'(rd_pending), 64'h0);

    // Collision with same-cycle bypass.
    idle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd7;
    cycle("coll7");
    chk("coll7_byp", 64'(rd_data[31:0]), 64'h11111111);
    idle(); rd_en = 2'b01; rd_addr[0 +: AW] = 5'd7;
    cycle("rd7");
    chk("rd7_stored", 64'(rd_data[31:0]), 64'h11111111);

    // Register 0 writes and issue have no effect.
    idle();
    wa_en = 1'b1; wa_addr = '0; wa_data = 32'hFFFFFFFF;
    wb_en = 1'b1; wb_addr = '0; wb_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = '0;
    cycle("wr0");
    idle(); rd_en = 2'b01; rd_addr[0 +: AW] = '0;
    cycle("rd0");
    chk("rd0_data", 64'(rd_data[31:0]), 64'h0);
    chk("rd0_pend", 64'(rd_pending[0]), 64'h0);
    chk("rd0_any", 64'(any_pending), 64'h0);

    // Scoreboard set, read while pending, cleared by load return.
    idle(); issue_en = 1'b1; issue_addr = 5'd9;
    cycle("iss9");
    idle(); rd_en = 2'b01; rd_addr[0 +: AW] = 5'd9;
    cycle("rd9_pend");
    chk("rd9_pend", 64'(rd_pending[0]), 64'h1);
    chk("rd9_any", 64'(any_pending), 64'h1);
    idle(); wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    rd_en = 2'b10; rd_addr[AW +: AW] = 5'd9;
    cycle("wb9");
    chk("wb9_byp", 64'(rd_data[63:32]), 64'h55);
    chk("wb9_pend", 64'(rd_pending[1]), 64'h0);
    idle();
    cycle("after9");
    chk("after9_any", 64'(any_pending), 64'h0);

    // Issue/write race, then async reset between edges.
    idle();
    issue_en = 1'b1; issue_addr = 5'd4;
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hA5A5A5A5;
    cycle("race4");
    chk("race4_any", 64'(any_pending), 64'h1);
    idle();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    rst = 1'b1;
    rd_en = 2'b01; rd_addr[0 +: AW] = 5'd4;
    cycle("rd4_rst");
    chk("rd4_rst_data", 64'(rd_data[31:0]), 64'h0);
    chk("rd4_rst_pend", 64'(rd_pending[0]), 64'h0);

    // Randomized run against the model, with occasional mid-run resets.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 79) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero($sformatf("rnd_rst%0d", n));
        rst = 1'b1;
      end
      cycle($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
